// File: rtl/wavetable_reader_if.sv
// Wavetable RAM read port: address/enables out of the reader, registered read data back in.
interface wavetable_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ce;
  logic              ram_re;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_addr, ram_ce, ram_re, ram_we,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr, ram_ce, ram_re, ram_we,
    output ram_rdata
  );
endinterface

// File: rtl/wavetable_reader.sv
// Phase-accumulator wavetable playback: one unsigned sample per accepted tick from a 1-cycle-latency RAM.
// Define WAVE_INTERP_EN to linearly interpolate between adjacent table entries (latency 5 instead of 3).
module wavetable_reader #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic                note_on,
  input  logic [PHASE_W-1:0]  phase_inc,
  wavetable_reader_if.master  ram,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);

  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_CAP,
    S_CALC
  } state_t;

  state_t              state_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [PHASE_W-1:0]  phase_d;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_rd_q;
  logic [DATA_W-1:0]   sample_q;
  logic                vld_q;
  logic                overrun_q;
  logic [ADDR_W-1:0]   index;

`ifdef WAVE_INTERP_EN
  logic [DATA_W-1:0]   s0_q;
  logic [DATA_W-1:0]   s1_q;
  logic [7:0]          frac_q;
  logic [7:0]          frac;

  // s0 + ((s1 - s0) * frac) >>> 8; the result lies between s0 and s1 so truncation is lossless.
  function automatic logic [DATA_W-1:0] lerp(input logic [DATA_W-1:0] s0,
                                             input logic [DATA_W-1:0] s1,
                                             input logic [7:0]        fr);
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W+8:0] prod;
    logic signed [DATA_W+8:0] sum;
    diff = $signed({1'b0, s1}) - $signed({1'b0, s0});
    prod = (DATA_W+9)'(diff) * (DATA_W+9)'($signed({1'b0, fr}));
    sum  = $signed({9'b0, s0}) + (prod >>> 8);
    return DATA_W'(sum);
  endfunction

  assign frac = phase_q[PHASE_W-ADDR_W-1 -: 8];
`endif

  // Lookup uses the pre-increment phase.
  assign index   = phase_q[PHASE_W-1 -: ADDR_W];
  assign phase_d = phase_q + phase_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      sample_q   <= MIDSCALE;
      vld_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (sample_tick && (state_q != S_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (sample_tick) begin
            if (note_on) begin
              phase_q    <= phase_d;
              ram_addr_q <= index;
              ram_rd_q   <= 1'b1;
`ifdef WAVE_INTERP_EN
              frac_q     <= frac;
`endif
              state_q    <= S_RD0;
            end else begin
              phase_q  <= '0;
              sample_q <= MIDSCALE;
              vld_q    <= 1'b1;
            end
          end
        end
        // --- read cycle 0: RAM samples index this cycle ---
        S_RD0: begin
`ifdef WAVE_INTERP_EN
          ram_addr_q <= ram_addr_q + ADDR_W'(1);
          state_q    <= S_RD1;
`else
          ram_rd_q   <= 1'b0;
          state_q    <= S_CAP;
`endif
        end
`ifdef WAVE_INTERP_EN
        // --- read cycle 1: data for index arrives, index+1 is requested ---
        S_RD1: begin
          s0_q     <= ram.ram_rdata;
          ram_rd_q <= 1'b0;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          s1_q    <= ram.ram_rdata;
          state_q <= S_CALC;
        end
        // --- blend stage ---
        S_CALC: begin
          sample_q <= lerp(s0_q, s1_q, frac_q);
          vld_q    <= 1'b1;
          state_q  <= S_IDLE;
        end
`else
        S_CAP: begin
          sample_q <= ram.ram_rdata;
          vld_q    <= 1'b1;
          state_q  <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram.ram_addr  = ram_addr_q;
  assign ram.ram_ce    = ram_rd_q;
  assign ram.ram_re    = ram_rd_q;
  assign ram.ram_we    = 1'b0;
  assign sample_out    = sample_q;
  assign sample_valid  = vld_q;
  assign busy          = (state_q != S_IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_wavetable_reader.sv
// Self-checking bench for wavetable_reader: RAM model, phase/sample reference model, directed and random ticks.
module tb_wavetable_reader;

`ifdef WAVE_INTERP_EN
  localparam int LAT = 5;
  localparam int NRE = 2;
`else
  localparam int LAT = 3;
  localparam int NRE = 1;
`endif

  logic        clk;
  logic        reset;
  logic        sample_tick;
  logic        note_on;
  logic [23:0] phase_inc;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int vectors;
  int miscompares;
  int model_phase;
  logic [15:0] mem [512];

  wavetable_reader_if #(.ADDR_W(9), .DATA_W(16)) ram_if ();

  wavetable_reader #(.ADDR_W(9), .DATA_W(16), .PHASE_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .note_on      (note_on),
    .phase_inc    (phase_inc),
    .ram          (ram_if),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_if.ram_ce && ram_if.ram_re) ram_if.ram_rdata <= mem[ram_if.ram_addr];

  function automatic int floor_div256(input int p);
    int r;
    r = ((p % 256) + 256) % 256;
    return (p - r) / 256;
  endfunction

  function automatic int model_index(input int ph);
    return (ph / 32768) % 512;
  endfunction

  function automatic logic [15:0] model_sample(input int ph);
    int idx, fr, s0, s1;
    idx = model_index(ph);
    s0  = int'(mem[idx]);
`ifdef WAVE_INTERP_EN
    fr  = (ph / 128) % 256;
    s1  = int'(mem[(idx + 1) % 512]);
    return 16'(s0 + floor_div256((s1 - s0) * fr));
`else
    fr  = 0;
    s1  = 0;
    return 16'(s0 + fr + s1);
`endif
  endfunction

  // Apply one tick, then watch ncyc cycles; caller must be #1 after a clock edge.
  task automatic run_tick(input logic nt, input logic [23:0] inc, input int ncyc,
                          output int vld_k, output int vld_cnt, output int re_cnt,
                          output logic [8:0] a0, output logic [8:0] a1,
                          output logic [15:0] smp, output int bad);
    vld_k = -1; vld_cnt = 0; re_cnt = 0; a0 = 'x; a1 = 'x; smp = 'x; bad = 0;
    note_on = nt; phase_inc = inc; sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (ram_if.ram_re === 1'b1) begin
        if (re_cnt == 0) a0 = ram_if.ram_addr;
        if (re_cnt == 1) a1 = ram_if.ram_addr;
        re_cnt++;
      end
      if (ram_if.ram_ce !== ram_if.ram_re) bad++;
      if (ram_if.ram_we !== 1'b0) bad++;
      if (sample_valid === 1'b1) begin
        vld_cnt++; vld_k = k; smp = sample_out;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; sample_tick = 1'b0; note_on = 1'b0; phase_inc = '0;
    repeat (3) @(posedge clk);
    #1;
    model_phase = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (sample_out !== 16'h8000) begin miscompares++; $display("FAIL reset_sample: got %h want 8000", sample_out); end
    vectors++; if ({sample_valid, busy, overrun} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {sample_valid, busy, overrun}); end
    vectors++; if ({ram_if.ram_ce, ram_if.ram_re, ram_if.ram_we} !== 3'b000) begin miscompares++; $display("FAIL reset_ram_ctl: got %b want 000", {ram_if.ram_ce, ram_if.ram_re, ram_if.ram_we}); end
    vectors++; if (ram_if.ram_addr !== 9'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", ram_if.ram_addr); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int vk, vc, rc, bd; logic [8:0] a0, a1; logic [15:0] s, exp_s; int exp_a;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0080);
    for (int i = 0; i < 4; i++) begin
      exp_a = model_index(model_phase);
      exp_s = model_sample(model_phase);
      model_phase = (model_phase + 24'h008000) % (1 << 24);
      run_tick(1'b1, 24'h008000, 7, vk, vc, rc, a0, a1, s, bd);
      vectors++; if (int'(a0) !== exp_a) begin miscompares++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, a0, exp_a); end
      vectors++; if (s !== exp_s) begin miscompares++; $display("FAIL basic_sample[%0d]: got %h want %h", i, s, exp_s); end
      vectors++; if (vk !== LAT || vc !== 1) begin miscompares++; $display("FAIL basic_valid[%0d]: got at %0d x%0d want at %0d x1", i, vk, vc, LAT); end
      vectors++; if (rc !== NRE || bd !== 0) begin miscompares++; $display("FAIL basic_re[%0d]: got re %0d bad %0d want re %0d bad 0", i, rc, bd, NRE); end
    end
  endtask

  task automatic test_wrap();
    int vk, vc, rc, bd; logic [8:0] a0, a1; logic [15:0] s, exp_s;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 16'h0080);
    run_tick(1'b0, 24'h000000, 3, vk, vc, rc, a0, a1, s, bd);
    model_phase = 0;
    run_tick(1'b1, 24'hFF8000, 7, vk, vc, rc, a0, a1, s, bd);
    model_phase = 24'hFF8000;
    for (int i = 0; i < 2; i++) begin
      exp_s = model_sample(model_phase);
      run_tick(1'b1, 24'h008000, 7, vk, vc, rc, a0, a1, s, bd);
      vectors++; if (a0 !== ((i == 0) ? 9'd511 : 9'd0)) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, a0, (i == 0) ? 511 : 0); end
      vectors++; if (s !== exp_s) begin miscompares++; $display("FAIL wrap_sample[%0d]: got %h want %h", i, s, exp_s); end
      model_phase = (model_phase + 24'h008000) % (1 << 24);
    end
  endtask

  task automatic test_overrun();
    int vc, vk, rc, bd; logic [8:0] a0, a1; logic [15:0] s, got_s, exp_s;
    vc = 0; got_s = 'x;
    exp_s = model_sample(model_phase);
    note_on = 1'b1; phase_inc = 24'h008000; sample_tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (sample_valid === 1'b1) begin vc++; got_s = sample_out; end
      @(posedge clk); #1;
    end
    model_phase = (model_phase + 24'h008000) % (1 << 24);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b want 1", overrun); end
    vectors++; if (vc !== 1 || got_s !== exp_s) begin miscompares++; $display("FAIL overrun_sample: got x%0d %h want x1 %h", vc, got_s, exp_s); end
    run_tick(1'b1, 24'h008000, 7, vk, vc, rc, a0, a1, s, bd);
    vectors++; if (int'(a0) !== model_index(model_phase)) begin miscompares++; $display("FAIL overrun_phase_once: got %0d want %0d", a0, model_index(model_phase)); end
    model_phase = (model_phase + 24'h008000) % (1 << 24);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_abort();
    int vc;
    vc = 0;
    note_on = 1'b1; phase_inc = 24'h008000; sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if ({ram_if.ram_ce, ram_if.ram_re} !== 2'b00) begin miscompares++; $display("FAIL abort_ram_ctl: got %b want 00", {ram_if.ram_ce, ram_if.ram_re}); end
    vectors++; if (sample_out !== 16'h8000 || sample_valid !== 1'b0) begin miscompares++; $display("FAIL abort_sample: got %h/%b want 8000/0", sample_out, sample_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL abort_overrun_clear: got %b want 0", overrun); end
    reset = 1'b0;
    model_phase = 0;
    for (int k = 0; k < 6; k++) begin
      if (sample_valid !== 1'b0 || ram_if.ram_re !== 1'b0) vc++;
      @(posedge clk); #1;
    end
    vectors++; if (vc !== 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles want 0", vc); end
  endtask

  task automatic test_mute();
    int vk, vc, rc, bd; logic [8:0] a0, a1; logic [15:0] s;
    run_tick(1'b1, 24'h123456, 7, vk, vc, rc, a0, a1, s, bd);
    run_tick(1'b0, 24'h0A0A0A, 4, vk, vc, rc, a0, a1, s, bd);
    model_phase = 0;
    vectors++; if (vk !== 1 || vc !== 1 || s !== 16'h8000) begin miscompares++; $display("FAIL mute_pulse: got at %0d x%0d %h want at 1 x1 8000", vk, vc, s); end
    vectors++; if (rc !== 0) begin miscompares++; $display("FAIL mute_no_ram: got %0d reads want 0", rc); end
    run_tick(1'b1, 24'h010000, 7, vk, vc, rc, a0, a1, s, bd);
    vectors++; if (a0 !== 9'd0) begin miscompares++; $display("FAIL mute_phase_zero: got %0d want 0", a0); end
    model_phase = 24'h010000;
  endtask

`ifdef WAVE_INTERP_EN
  task automatic test_interp();
    int vk, vc, rc, bd; logic [8:0] a0, a1; logic [15:0] s;
    mem[0] = 16'h1000; mem[1] = 16'h2000; mem[511] = 16'h3000;
    run_tick(1'b0, 24'h0, 3, vk, vc, rc, a0, a1, s, bd);
    run_tick(1'b1, 24'h004000, 7, vk, vc, rc, a0, a1, s, bd);
    run_tick(1'b1, 24'h000000, 7, vk, vc, rc, a0, a1, s, bd);
    vectors++; if (s !== 16'h1800 || vk !== 5) begin miscompares++; $display("FAIL interp_mid: got %h at %0d want 1800 at 5", s, vk); end
    run_tick(1'b0, 24'h0, 3, vk, vc, rc, a0, a1, s, bd);
    run_tick(1'b1, 24'hFFC000, 7, vk, vc, rc, a0, a1, s, bd);
    run_tick(1'b1, 24'h000000, 7, vk, vc, rc, a0, a1, s, bd);
    vectors++; if (a0 !== 9'd511 || a1 !== 9'd0) begin miscompares++; $display("FAIL interp_wrap_addr: got %0d,%0d want 511,0", a0, a1); end
    vectors++; if (s !== 16'h2000) begin miscompares++; $display("FAIL interp_wrap_sample: got %h want 2000", s); end
    model_phase = 24'hFFC000;
  endtask
`endif

  task automatic test_random();
    int vk, vc, rc, bd; logic [8:0] a0, a1; logic [15:0] s, exp_s; logic nt; logic [23:0] inc;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 40; n++) begin
      nt  = ($urandom_range(0, 5) != 0);
      inc = 24'($urandom);
      if (nt) begin
        exp_s = model_sample(model_phase);
        run_tick(1'b1, inc, 7, vk, vc, rc, a0, a1, s, bd);
        vectors++; if (int'(a0) !== model_index(model_phase) || s !== exp_s || vk !== LAT) begin
          miscompares++; $display("FAIL random[%0d]: got addr %0d smp %h at %0d want addr %0d smp %h at %0d", n, a0, s, vk, model_index(model_phase), exp_s, LAT);
        end
        model_phase = (model_phase + int'(inc)) % (1 << 24);
      end else begin
        run_tick(1'b0, inc, 7, vk, vc, rc, a0, a1, s, bd);
        vectors++; if (s !== 16'h8000 || vk !== 1 || rc !== 0) begin
          miscompares++; $display("FAIL random_mute[%0d]: got %h at %0d reads %0d want 8000 at 1 reads 0", n, s, vk, rc);
        end
        model_phase = 0;
      end
      vectors++; if (bd !== 0) begin miscompares++; $display("FAIL random_ramctl[%0d]: got %0d bad cycles want 0", n, bd); end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; model_phase = 0;
    reset = 1'b1; sample_tick = 1'b0; note_on = 1'b0; phase_inc = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_overrun();
    test_reset_abort();
    test_mute();
`ifdef WAVE_INTERP_EN
    test_interp();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
